// File: rtl/oled_phase_scheduler.sv
// OLED display-path sequencer: init, clear, glyphs, periodic numbers.
// Owns the single IIC frame writer and gates write_done per phase.
module oled_phase_scheduler #(
  parameter int REFRESH_CYCLES = 5_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter bit AUTO_START     = 1'b1
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        force_refresh,
  output logic        init_req,
  input  logic [23:0] init_data,
  input  logic        init_finish,
  output logic        clear_req,
  input  logic [23:0] clear_data,
  input  logic        clear_finish,
  output logic        font_req,
  input  logic [23:0] font_data,
  input  logic        font_finish,
  output logic        num_req,
  input  logic [23:0] num_data,
  input  logic        num_finish,
  output logic        init_done,
  output logic        clear_done,
  output logic        font_done,
  output logic        num_done,
  output logic        iic_wr_req,
  output logic [23:0] iic_wr_data,
  input  logic        iic_write_done,
  output logic        busy,
  output logic [2:0]  phase,
  output logic        err
);

  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] REF_TC =
    RW'(REFRESH_CYCLES - 1);
  localparam logic [WW-1:0] WDT_TC =
    WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CLEAR = 3'd2,
    S_FONT  = 3'd3,
    S_NUM   = 3'd4,
    S_HOLD  = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t        r_state;
  state_t        r_gap_nxt;
  state_t        w_nxt;
  logic          r_init_req;
  logic          r_clear_req;
  logic          r_font_req;
  logic          r_num_req;
  logic          r_wr_req;
  logic          r_busy;
  logic          r_err;
  logic [RW-1:0] r_ref;
  logic [WW-1:0] r_wdt;
  logic          w_active;
  logic          w_fin;
  logic          w_wdt_hit;
  logic          w_to;
  logic [23:0]   w_data;

  function automatic state_t succ(input state_t s);
    case (s)
      S_INIT:  succ = S_CLEAR;
      S_CLEAR: succ = S_FONT;
      S_FONT:  succ = S_NUM;
      default: succ = S_HOLD;
    endcase
  endfunction

  always_comb begin
    w_fin    = 1'b0;
    w_data   = '0;
    w_active = 1'b1;
    unique case (r_state)
      S_INIT: begin
        w_fin  = init_finish;
        w_data = init_data;
      end
      S_CLEAR: begin
        w_fin  = clear_finish;
        w_data = clear_data;
      end
      S_FONT: begin
        w_fin  = font_finish;
        w_data = font_data;
      end
      S_NUM: begin
        w_fin  = num_finish;
        w_data = num_data;
      end
      default: w_active = 1'b0;
    endcase
  end

  assign w_wdt_hit = w_active && !iic_write_done &&
                     (r_wdt == WDT_TC);

  always_comb begin
    w_nxt = r_state;
    w_to  = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (AUTO_START || start) w_nxt = S_INIT;
      S_INIT, S_CLEAR, S_FONT, S_NUM:
        if (w_fin) begin
          w_nxt = S_GAP;
        end else if (w_wdt_hit) begin
          w_nxt = S_GAP;
          w_to  = 1'b1;
        end
      S_HOLD:
        if (force_refresh || r_ref == REF_TC)
          w_nxt = S_NUM;
      S_GAP:   w_nxt = r_gap_nxt;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gap_nxt   <= S_INIT;
      r_init_req  <= 1'b0;
      r_clear_req <= 1'b0;
      r_font_req  <= 1'b0;
      r_num_req   <= 1'b0;
      r_wr_req    <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_ref       <= '0;
      r_wdt       <= '0;
    end else begin
      r_state     <= w_nxt;
      r_init_req  <= (w_nxt == S_INIT);
      r_clear_req <= (w_nxt == S_CLEAR);
      r_font_req  <= (w_nxt == S_FONT);
      r_num_req   <= (w_nxt == S_NUM);
      r_wr_req    <= (w_nxt == S_INIT) ||
                     (w_nxt == S_CLEAR) ||
                     (w_nxt == S_FONT) ||
                     (w_nxt == S_NUM);
      r_busy      <= !((w_nxt == S_IDLE) ||
                       (w_nxt == S_HOLD));
      if (w_to) r_err <= 1'b1;
      // A watchdog expiry restarts the panel from init
      if (w_nxt == S_GAP && r_state != S_GAP)
        r_gap_nxt <= w_to ? S_INIT : succ(r_state);
      if (w_nxt != r_state || iic_write_done)
        r_wdt <= '0;
      else if (w_active && r_wdt != WDT_TC)
        r_wdt <= r_wdt + WW'(1);
      if (w_nxt != r_state)
        r_ref <= '0;
      else if (r_state == S_HOLD && r_ref != REF_TC)
        r_ref <= r_ref + RW'(1);
    end
  end

  assign init_req    = r_init_req;
  assign clear_req   = r_clear_req;
  assign font_req    = r_font_req;
  assign num_req     = r_num_req;
  assign iic_wr_req  = r_wr_req;
  assign iic_wr_data = w_data;
  assign busy        = r_busy;
  assign err         = r_err;
  assign phase       = r_state;

  assign init_done  = iic_write_done && (r_state == S_INIT);
  assign clear_done = iic_write_done && (r_state == S_CLEAR);
  assign font_done  = iic_write_done && (r_state == S_FONT);
  assign num_done   = iic_write_done && (r_state == S_NUM);

endmodule
